// File: rtl/pht_ctrl.sv
// rtl/pht_ctrl.sv - PHT SRAM controller: init sweep, predict lookups, queued 2-bit counter updates
// Lookups and update RMWs share the SRAM read port; a one-entry write buffer covers write-to-read latency.
module pht_ctrl #(
   parameter int unsigned          ADDR_WIDTH   = 8,
   parameter int unsigned          CTR_WIDTH    = 2,
   parameter logic [CTR_WIDTH-1:0] INIT_VAL     = 2'b01,
   parameter int unsigned          UPD_DEPTH    = 4,
   parameter int unsigned          STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pred_valid,
   input  logic [ADDR_WIDTH-1:0] pred_idx,
   output logic                  pred_ready,
   output logic                  pred_rsp_valid,
   output logic                  pred_taken,
   output logic [CTR_WIDTH-1:0]  pred_ctr,
   input  logic                  upd_valid,
   input  logic [ADDR_WIDTH-1:0] upd_idx,
   input  logic                  upd_taken,
   output logic                  upd_ready,
   output logic                  init_done,
   output logic                  sram_csb0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [CTR_WIDTH-1:0]  sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [CTR_WIDTH-1:0]  sram_dout1
);

   localparam int unsigned PTR_W = $clog2(UPD_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e                                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]                  init_idx_q, init_idx_d;
   logic [UPD_DEPTH-1:0][ADDR_WIDTH-1:0]   fifo_idx_q, fifo_idx_d;
   logic [UPD_DEPTH-1:0]                   fifo_tkn_q, fifo_tkn_d;
   logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                       count_q, count_d;
   logic [STV_W-1:0]                       starve_q, starve_d;
   logic                                   rd_lookup_q, rd_lookup_d;
   logic                                   rd_rmw_q, rd_rmw_d;
   logic                                   rd_tkn_q, rd_tkn_d;
   logic [ADDR_WIDTH-1:0]                  rd_idx_q, rd_idx_d;
   logic                                   wbuf_valid_q, wbuf_valid_d;
   logic [ADDR_WIDTH-1:0]                  wbuf_idx_q, wbuf_idx_d;
   logic [CTR_WIDTH-1:0]                   wbuf_data_q, wbuf_data_d;
   logic [CTR_WIDTH-1:0]                   pred_ctr_q, pred_ctr_d;

   logic                  run, fifo_empty, fifo_full, starved;
   logic                  issue_rmw, issue_lookup, push;
   logic                  pred_ready_int, upd_ready_int, fwd_hit;
   logic [ADDR_WIDTH-1:0] head_idx;
   logic [CTR_WIDTH-1:0]  rdata, new_ctr, ctr_out;

   always_comb begin
      run            = (state_q == ST_RUN);
      fifo_empty     = (count_q == '0);
      fifo_full      = (count_q == CNT_W'(UPD_DEPTH));
      starved        = (starve_q == STV_W'(STARVE_LIMIT));
      head_idx       = fifo_idx_q[rd_ptr_q];
      issue_rmw      = run && !fifo_empty && (!pred_valid || starved);
      pred_ready_int = run && !(issue_rmw && starved);
      issue_lookup   = pred_valid && pred_ready_int;
      upd_ready_int  = run && !fifo_full;
      push           = upd_valid && upd_ready_int;

      // The write driven last cycle is not yet visible on dout1; take it from wbuf instead.
      fwd_hit = wbuf_valid_q && (wbuf_idx_q == rd_idx_q);
      rdata   = fwd_hit ? wbuf_data_q : sram_dout1;
      if (rd_tkn_q) new_ctr = (rdata == '1) ? rdata : rdata + CTR_WIDTH'(1);
      else          new_ctr = (rdata == '0) ? rdata : rdata - CTR_WIDTH'(1);

      state_d    = state_q;
      init_idx_d = init_idx_q;
      if (!run) begin
         init_idx_d = init_idx_q + ADDR_WIDTH'(1);
         if (init_idx_q == '1) state_d = ST_RUN;
      end

      fifo_idx_d = fifo_idx_q;
      fifo_tkn_d = fifo_tkn_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) begin
         fifo_idx_d[wr_ptr_q] = upd_idx;
         fifo_tkn_d[wr_ptr_q] = upd_taken;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (issue_rmw) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q + CNT_W'(push) - CNT_W'(issue_rmw);
      starve_d = (fifo_empty || issue_rmw) ? '0 : starve_q + STV_W'(1);

      rd_lookup_d  = issue_lookup;
      rd_rmw_d     = issue_rmw;
      rd_idx_d     = issue_rmw ? head_idx : pred_idx;
      rd_tkn_d     = fifo_tkn_q[rd_ptr_q];
      wbuf_valid_d = run && rd_rmw_q;
      wbuf_idx_d   = rd_idx_q;
      wbuf_data_d  = new_ctr;
      ctr_out      = rd_lookup_q ? rdata : pred_ctr_q;
      pred_ctr_d   = ctr_out;

      init_done      = run;
      upd_ready      = rst_n && upd_ready_int;
      pred_ready     = rst_n && pred_ready_int;
      pred_rsp_valid = rd_lookup_q;
      pred_ctr       = ctr_out;
      pred_taken     = ctr_out[CTR_WIDTH-1];
      sram_csb1      = !(rst_n && (issue_rmw || issue_lookup));
      sram_addr1     = issue_rmw ? head_idx : pred_idx;
      if (!run) begin
         sram_csb0  = !rst_n;
         sram_addr0 = init_idx_q;
         sram_din0  = INIT_VAL;
      end else begin
         sram_csb0  = !(rst_n && rd_rmw_q);
         sram_addr0 = rd_idx_q;
         sram_din0  = new_ctr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         init_idx_q   <= '0;
         fifo_idx_q   <= '0;
         fifo_tkn_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_q     <= '0;
         rd_lookup_q  <= 1'b0;
         rd_rmw_q     <= 1'b0;
         rd_tkn_q     <= 1'b0;
         rd_idx_q     <= '0;
         wbuf_valid_q <= 1'b0;
         wbuf_idx_q   <= '0;
         wbuf_data_q  <= '0;
         pred_ctr_q   <= '0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         fifo_idx_q   <= fifo_idx_d;
         fifo_tkn_q   <= fifo_tkn_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_q     <= starve_d;
         rd_lookup_q  <= rd_lookup_d;
         rd_rmw_q     <= rd_rmw_d;
         rd_tkn_q     <= rd_tkn_d;
         rd_idx_q     <= rd_idx_d;
         wbuf_valid_q <= wbuf_valid_d;
         wbuf_idx_q   <= wbuf_idx_d;
         wbuf_data_q  <= wbuf_data_d;
         pred_ctr_q   <= pred_ctr_d;
      end
   end

endmodule
